// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: in-order dispatch stage between the instruction queue and
// the four reservation queues (INT, MULT, DIV, MEM).
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   ifq_valid/ifq_inst/ifq_pc    instruction-queue head
//   ifq_pop                      pops the head this cycle
//   *_full / *_we                reservation-queue full flags / write enables
//   disp_inst/disp_pc/disp_tag   dispatch payload (valid when a *_we is high)
//   disp_reg_write               dispatched instruction writes rd
//   jmp_o, invalid_op            JAL redirect pulse, illegal-opcode pulse
//   br_done, retire, flush       branch resolved, one retirement, pipeline flush
//   stall                        head valid but not popped this cycle
//   dbg_state, dbg_count         FSM state (RUN=0, WAIT_BR=1, JUMP=2) and
//                                outstanding count, for observation
//
// Handshake: ifq_valid is the producer's valid and ifq_pop is our ready; a
// head transfers exactly in a cycle where both are high. The *_we strobes
// are single-cycle pushes; the consumer signals back-pressure only through
// its *_full flag, sampled in the same cycle.
module dispatch_ctrl #(
   parameter int TAG_W   = 5,
   parameter int MAX_OUT = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           ifq_valid,
   input  logic [31:0]                    ifq_inst,
   input  logic [31:0]                    ifq_pc,
   output logic                           ifq_pop,
   input  logic                           int_full,
   input  logic                           mult_full,
   input  logic                           div_full,
   input  logic                           mem_full,
   output logic                           int_we,
   output logic                           mult_we,
   output logic                           div_we,
   output logic                           mem_we,
   output logic [31:0]                    disp_inst,
   output logic [31:0]                    disp_pc,
   output logic [TAG_W-1:0]               disp_tag,
   output logic                           disp_reg_write,
   output logic                           jmp_o,
   output logic                           invalid_op,
   input  logic                           br_done,
   input  logic                           retire,
   input  logic                           flush,
   output logic                           stall,
   output logic [1:0]                     dbg_state,
   output logic [$clog2(MAX_OUT+1)-1:0]   dbg_count
);

   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

   typedef enum logic [1:0] {RUN = 2'd0, WAIT_BR = 2'd1, JUMP = 2'd2} state_t;
   typedef enum logic [2:0] {C_INT, C_MULT, C_DIV, C_MEM, C_INVALID} cls_t;

   state_t            state_q, state_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [CNT_W-1:0]  count_q, count_d;

   cls_t  cls;
   logic  reg_wr, is_br, is_jal, is_jalr;
   logic  target_full, can_issue, do_disp, do_inv, dec;

   // Opcode decode into a target class plus control-flow flags.
   always_comb begin
      cls     = C_INVALID;
      reg_wr  = 1'b0;
      is_br   = 1'b0;
      is_jal  = 1'b0;
      is_jalr = 1'b0;
      case (ifq_inst[6:0])
         7'b0110011: begin
            reg_wr = 1'b1;
            if (ifq_inst[31:25] == 7'b0000001)
               cls = (ifq_inst[14:12] < 3'd4) ? C_MULT : C_DIV;
            else
               cls = C_INT;
         end
         7'b0010011, 7'b0110111, 7'b0010111: begin
            cls = C_INT;  reg_wr = 1'b1;
         end
         7'b0000011: begin cls = C_MEM; reg_wr = 1'b1; end
         7'b0100011: begin cls = C_MEM; reg_wr = 1'b0; end
         7'b1100011: begin cls = C_INT; is_br  = 1'b1; end
         7'b1101111: begin cls = C_INT; is_jal = 1'b1; reg_wr = 1'b1; end
         7'b1100111: begin cls = C_INT; is_jalr = 1'b1; reg_wr = 1'b1; end
         default:    cls = C_INVALID;
      endcase
   end

   always_comb begin
      case (cls)
         C_INT:   target_full = int_full;
         C_MULT:  target_full = mult_full;
         C_DIV:   target_full = div_full;
         C_MEM:   target_full = mem_full;
         default: target_full = 1'b0;
      endcase
   end

   // rst_n is folded in so every strobe is forced low while reset is held,
   // not just after the next edge.
   assign can_issue = rst_n && (state_q == RUN) && !flush && ifq_valid;
   assign do_disp   = can_issue && (cls != C_INVALID) && !target_full && (count_q < MAX_CNT);
   // Illegal heads are dropped even under back-pressure so they cannot wedge the queue.
   assign do_inv    = can_issue && (cls == C_INVALID);
   assign dec       = retire && (count_q != '0);

   assign ifq_pop        = do_disp || do_inv;
   assign int_we         = do_disp && (cls == C_INT);
   assign mult_we        = do_disp && (cls == C_MULT);
   assign div_we         = do_disp && (cls == C_DIV);
   assign mem_we         = do_disp && (cls == C_MEM);
   assign jmp_o          = do_disp && is_jal;
   assign invalid_op     = do_inv;
   assign disp_reg_write = do_disp && reg_wr;
   assign disp_inst      = ifq_inst;
   assign disp_pc        = ifq_pc;
   assign disp_tag       = tag_q;
   assign stall          = rst_n && ifq_valid && !ifq_pop;
   assign dbg_state      = state_q;
   assign dbg_count      = count_q;

   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      count_d = count_q;
      if (flush) begin
         // Flush wins over everything; the tag keeps running so stale tags
         // still in flight can never alias fresh ones.
         state_d = RUN;
         count_d = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (do_disp && (is_br || is_jalr)) state_d = WAIT_BR;
               else if (do_disp && is_jal)        state_d = JUMP;
            end
            WAIT_BR: if (br_done) state_d = RUN;
            JUMP:    state_d = RUN;
            default: state_d = RUN;
         endcase
         if (do_disp) tag_d = tag_q + TAG_W'(1);
         if (do_disp && !dec)      count_d = count_q + CNT_W'(1);
         else if (!do_disp && dec) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         tag_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         count_q <= count_d;
      end
   end

endmodule
